// File: rtl/re_fifo_pkg.sv
// re_fifo_pkg: shared types and sizes for the HL re-injection FIFO.
//   MADDR / MSRC_BW : router address and source-field widths (bitmap is MADDR+1,
//                     source-destination field is MSRC_BW+1)
//   RE_DEPTH        : default number of entries (power of two)
//   RE_PTRW         : pointer width for the default depth
//   RE_CNTW         : occupancy counter width for the default depth
//   re_entry_t      : one stored re-injection request {doc, src_pos, src_dst}
package re_fifo_pkg;

    localparam int MADDR     = 11;
    localparam int MSRC_BW   = 3;
    localparam int DOC_W     = MADDR + 1;
    localparam int SRC_DST_W = MSRC_BW + 1;

    localparam int RE_DEPTH  = 4;
    localparam int RE_PTRW   = $clog2(RE_DEPTH);
    localparam int RE_CNTW   = RE_PTRW + 1;

    typedef struct packed {
        logic [DOC_W-1:0]     doc;
        logic [1:0]           src_pos;
        logic [SRC_DST_W-1:0] src_dst;
    } re_entry_t;

endpackage

// File: rtl/re_fifo_hl_if.sv
// re_fifo_hl_if: decoder <-> re-injection FIFO bundle.
//   Write side : wr_en, wr_doc, wr_src_pos, wr_src_dst (decoder -> FIFO), full
//   Read side  : rd_valid, rd_doc, rd_src_pos, rd_src_dst (FIFO -> decoder), rd_ack
//   Status     : count, overflow
//
// Handshake: the head entry transfers on a cycle where rd_valid && rd_ack are
// both high at the rising edge; rd_ack with rd_valid low has no effect. The
// write side has no back-pressure wire: a push (wr_en) while full is accepted
// only if the head is popped in the same cycle, otherwise it is dropped and
// flagged through the sticky overflow bit.
//   master : decoder side
//   slave  : FIFO side
interface re_fifo_hl_if import re_fifo_pkg::*; #(
    parameter int CNTW = RE_CNTW
);
    logic                 wr_en;
    logic [DOC_W-1:0]     wr_doc;
    logic [1:0]           wr_src_pos;
    logic [SRC_DST_W-1:0] wr_src_dst;
    logic                 full;
    logic                 rd_valid;
    logic [DOC_W-1:0]     rd_doc;
    logic [1:0]           rd_src_pos;
    logic [SRC_DST_W-1:0] rd_src_dst;
    logic                 rd_ack;
    logic [CNTW-1:0]      count;
    logic                 overflow;

    modport master (
        output wr_en, wr_doc, wr_src_pos, wr_src_dst, rd_ack,
        input  full, rd_valid, rd_doc, rd_src_pos, rd_src_dst, count, overflow
    );

    modport slave (
        input  wr_en, wr_doc, wr_src_pos, wr_src_dst, rd_ack,
        output full, rd_valid, rd_doc, rd_src_pos, rd_src_dst, count, overflow
    );

endinterface

// File: rtl/re_fifo_mem.sv
// re_fifo_mem: DEPTH x re_entry_t storage, one synchronous write port and one
// asynchronous read port. No reset: contents are meaningless until written and
// the owner never exposes an unwritten slot.
//   clk   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : entry to store
//   raddr : read slot
//   rdata : entry at raddr (combinational)
module re_fifo_mem import re_fifo_pkg::*; #(
    parameter int DEPTH = RE_DEPTH,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PTRW-1:0] waddr,
    input  re_entry_t       wdata,
    input  logic [PTRW-1:0] raddr,
    output re_entry_t       rdata
);

    re_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/re_fifo_hl.sv
// re_fifo_hl: re-injection FIFO for the HL multicast router input stage.
// Holds the remaining destination set of split multicast flits and re-presents
// them to the decoder in arrival order until each is acknowledged.
//   clk, rst : clock, synchronous active-high reset
//   bus      : re_fifo_hl_if.slave (write side, read side, count, overflow)
// Build option:
//   RE_FIFO_ZERO_FILTER_EN : when defined, pushes with wr_doc == 0 are
//                            discarded without occupying an entry or raising
//                            overflow.
module re_fifo_hl import re_fifo_pkg::*; #(
    parameter int DEPTH = RE_DEPTH,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    re_fifo_hl_if.slave  bus
);

    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count_q;
    logic            overflow_q;

    logic      rd_valid_w;
    logic      full_w;
    logic      push_req;
    logic      push;
    logic      pop;
    logic      drop;
    re_entry_t wr_entry;
    re_entry_t head;

    assign rd_valid_w = (count_q != '0);
    assign full_w     = (count_q == CNTW'(DEPTH));

`ifdef RE_FIFO_ZERO_FILTER_EN
    // Empty remainders never become requests, so they are neither stored nor
    // counted as drops.
    assign push_req = bus.wr_en && (bus.wr_doc != '0);
`else
    assign push_req = bus.wr_en;
`endif

    assign pop  = bus.rd_ack && rd_valid_w;
    // A same-cycle pop frees the head slot, so a push into a full FIFO fits.
    assign push = push_req && (!full_w || pop);
    assign drop = push_req && full_w && !pop;

    assign wr_entry = '{doc: bus.wr_doc, src_pos: bus.wr_src_pos, src_dst: bus.wr_src_dst};

    re_fifo_mem #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNTW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.full       = full_w;
    assign bus.rd_valid   = rd_valid_w;
    assign bus.rd_doc     = rd_valid_w ? head.doc     : '0;
    assign bus.rd_src_pos = rd_valid_w ? head.src_pos : '0;
    assign bus.rd_src_dst = rd_valid_w ? head.src_dst : '0;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_re_fifo_hl.sv
// tb_re_fifo_hl: directed self-checking bench for re_fifo_hl (DEPTH = 4).
module tb_re_fifo_hl;
    import re_fifo_pkg::*;

    logic clk;
    logic rst;

    re_fifo_hl_if bus ();

    re_fifo_hl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [DOC_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs, take the edge, sample 1ns later, idle inputs.
    task automatic drive(input logic we, input logic [DOC_W-1:0] doc, input logic [1:0] pos,
                         input logic [SRC_DST_W-1:0] dst, input logic ack, input logic rs);
        rst            = rs;
        bus.wr_en      = we;
        bus.wr_doc     = doc;
        bus.wr_src_pos = pos;
        bus.wr_src_dst = dst;
        bus.rd_ack     = ack;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_doc     = '0;
        bus.wr_src_pos = '0;
        bus.wr_src_dst = '0;
        bus.rd_ack     = 1'b0;
    endtask

    task automatic push(input logic [DOC_W-1:0] doc);
        exp_q.push_back(doc);
        drive(1'b1, doc, 2'd0, '0, 1'b0, 1'b0);
    endtask

    // Pop every expected entry, checking head order against the queue.
    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("pop_order", 32'(bus.rd_doc), 32'(exp_q.pop_front()));
            drive(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
        end
        check("drain_count", 32'(bus.count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_doc     = '0;
        bus.wr_src_pos = '0;
        bus.wr_src_dst = '0;
        bus.rd_ack     = 1'b0;
        drive(1'b0, '0, 2'd0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 2'd0, '0, 1'b0, 1'b1);

        // Reset state
        check("rst_count",    32'(bus.count),    32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_full",     32'(bus.full),     32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_rd_doc",   32'(bus.rd_doc),   32'd0);

        // Single push: no same-cycle bypass, visible after the edge
        bus.wr_en      = 1'b1;
        bus.wr_doc     = 12'h0F0;
        bus.wr_src_pos = 2'd2;
        bus.wr_src_dst = 4'd5;
        #1;
        check("no_bypass", 32'(bus.rd_valid), 32'd0);
        exp_q.push_back(12'h0F0);
        drive(1'b1, 12'h0F0, 2'd2, 4'd5, 1'b0, 1'b0);
        check("one_rd_valid", 32'(bus.rd_valid),   32'd1);
        check("one_rd_doc",   32'(bus.rd_doc),     32'h0F0);
        check("one_src_pos",  32'(bus.rd_src_pos), 32'd2);
        check("one_src_dst",  32'(bus.rd_src_dst), 32'd5);
        check("one_count",    32'(bus.count),      32'd1);
        drain();
        check("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("empty_rd_doc",   32'(bus.rd_doc),   32'd0);

        // Fill to full, then overflow
        for (int i = 1; i <= 4; i++) begin
            push(DOC_W'(i));
            check("fill_count", 32'(bus.count), 32'(i));
        end
        check("fill_full", 32'(bus.full), 32'd1);
        drive(1'b1, 12'h005, 2'd0, '0, 1'b0, 1'b0);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count),    32'd4);
        check("ovf_head",  32'(bus.rd_doc),   32'h001);
        drain();
        check("drained_full", 32'(bus.full), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) push(DOC_W'(12'h010 + i));
        check("swap_head_before", 32'(bus.rd_doc), 32'h011);
        void'(exp_q.pop_front());
        exp_q.push_back(12'h100);
        drive(1'b1, 12'h100, 2'd0, '0, 1'b1, 1'b0);
        check("swap_count",    32'(bus.count),    32'd4);
        check("swap_full",     32'(bus.full),     32'd1);
        check("swap_head",     32'(bus.rd_doc),   32'h012);
        check("swap_overflow", 32'(bus.overflow), 32'd1);
        drain();

        // Simultaneous push and pop at count == 1
        push(12'h00A);
        void'(exp_q.pop_front());
        exp_q.push_back(12'h00B);
        drive(1'b1, 12'h00B, 2'd0, '0, 1'b1, 1'b0);
        check("c1_count", 32'(bus.count),  32'd1);
        check("c1_head",  32'(bus.rd_doc), 32'h00B);
        drain();

        // Ack while empty is ignored
        drive(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
        check("eack_count",    32'(bus.count),    32'd0);
        check("eack_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("eack_overflow", 32'(bus.overflow), 32'd1);

        // Zero-DOC push
        drive(1'b1, 12'h000, 2'd1, 4'd3, 1'b0, 1'b0);
`ifdef RE_FIFO_ZERO_FILTER_EN
        check("zero_count",    32'(bus.count),    32'd0);
        check("zero_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("zero_overflow", 32'(bus.overflow), 32'd1);
`else
        check("zero_count",    32'(bus.count),      32'd1);
        check("zero_rd_valid", 32'(bus.rd_valid),   32'd1);
        check("zero_rd_doc",   32'(bus.rd_doc),     32'd0);
        check("zero_src_pos",  32'(bus.rd_src_pos), 32'd1);
        drive(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
        check("zero_pop_count", 32'(bus.count), 32'd0);
`endif

        // Reset mid-operation together with a push
        for (int i = 1; i <= 3; i++) push(DOC_W'(12'h020 + i));
        check("pre_rst_count", 32'(bus.count), 32'd3);
        drive(1'b1, 12'h024, 2'd0, '0, 1'b0, 1'b1);
        exp_q.delete();
        check("mrst_count",    32'(bus.count),    32'd0);
        check("mrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("mrst_overflow", 32'(bus.overflow), 32'd0);
        check("mrst_full",     32'(bus.full),     32'd0);

        // Pointer wrap: six push/pop pairs with one entry in flight
        push(12'h030);
        for (int i = 1; i <= 6; i++) begin
            check("wrap_head", 32'(bus.rd_doc), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(DOC_W'(12'h030 + i));
            drive(1'b1, DOC_W'(12'h030 + i), 2'd0, '0, 1'b1, 1'b0);
            check("wrap_count", 32'(bus.count), 32'd1);
        end
        drain();
        check("end_overflow", 32'(bus.overflow), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/re_fifo_hl.md
# re_fifo_hl

Re-injection FIFO for the hierarchical-lookup (HL) multicast router input stage. It is directly downstream of the per-port destination decoder. When a multicast flit is split, the decoder forwards one half-DOC (dimension-order chain) to the crossbar. This block captures the remaining destination set (`doc_remain`) together with the source context. It then re-presents each captured entry to the decoder as a new multicast request, in arrival order, until the decoder consumes it.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `CNTW`, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  decoder pushes a remaining DOC this cycle.
- `wr_doc`  in  `MADDR`+1  remaining destination bitmap (`doc_remain`).
- `wr_src_pos`  in  2  source position code accompanying the flit.
- `wr_src_dst`  in  `MSRC_BW`+1  source-destination field accompanying the flit.
- `full`  out  1  occupancy == DEPTH.
- `rd_valid`  out  1  head entry available for re-injection.
- `rd_doc`  out  `MADDR`+1  head destination bitmap (fed to the decoder as `mult_dst`).
- `rd_src_pos`  out  2  head source position.
- `rd_src_dst`  out  `MSRC_BW`+1  head source-destination field.
- `rd_ack`  in  1  decoder accepted the head this cycle.
- `count`  out  `CNTW`  current occupancy.
- `overflow`  out  1  sticky flag: a write was dropped.

## Operation
- Circular buffer: `wr_ptr` and `rd_ptr` are each log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.
- Push accepted when `wr_en && (!full || (rd_ack && rd_valid))`. On accept, the entry is written at `wr_ptr` and `wr_ptr` increments.
- Push while full without a same-cycle pop is dropped. `overflow` is set and holds until `rst`. Storage and pointers are unchanged.
- Pop when `rd_ack && rd_valid`: `rd_ptr` increments.
- `rd_ack` while `!rd_valid` is ignored and is not an error.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance. This also applies when full and when count==1.
- `rd_*` are driven combinationally from `mem[rd_ptr]`; `rd_valid = (count != 0)`.
- When empty, `rd_doc`, `rd_src_pos` and `rd_src_dst` are forced to 0.
- Strict FIFO order: no reordering and no merging of entries.

## Timing
- Reset values: `count`=0, pointers=0, `full`=0, `rd_valid`=0, all `rd_*` data 0, `overflow`=0. Memory contents are don't-care.
- A reset asserted mid-operation discards all entries at the next edge. A push or pop in the reset cycle is ignored.
- Write-to-read latency is 1 cycle: a push at edge N makes `rd_valid`=1 after edge N. There is no same-cycle bypass.
- `full` and `count` update at the same edge as the push or pop that changes them.
- Pop-to-next-head: after a pop at edge N, the next entry is visible immediately after edge N.

## Configuration
- `RE_FIFO_ZERO_FILTER_EN` defined: a push with `wr_doc == 0` is silently discarded. It does not occupy an entry and does not set `overflow`. This lets the decoder drive `wr_en` for every multicast split, including row-state splits where the remainder is 0.
- Not defined: zero-DOC pushes are stored like any other entry. The decoder must gate `wr_en` itself.

## Structure
- Shared package `re_fifo_pkg`:
  - `re_entry_t` packed struct {doc, src_pos, src_dst}, sized from `MADDR` and `MSRC_BW`.
  - Localparams for the pointer width.
- One sub-module, `re_fifo_mem`: DEPTH×`re_entry_t` register array with a single write port and an asynchronous read port, reset-free.
- Pointer, count and flag logic stay in `re_fifo_hl`.

## Test plan
- Reset, then push doc=0x0F0, src_pos=2 -> next cycle `rd_valid`=1, `rd_doc`=0x0F0, `rd_src_pos`=2, `count`=1.
- Push doc 0x001, 0x002, 0x003, 0x004 on consecutive cycles with no ack -> `full`=1, `count`=4. A fifth push of 0x005 -> dropped, `overflow`=1. Acks then return 0x001..0x004 in order.
- Full FIFO, simultaneous push 0x100 and ack -> `count` stays 4, head advances, and 0x100 is returned last.
- Push 0x0 -> with `RE_FIFO_ZERO_FILTER_EN`, `count`=0 and `rd_valid`=0; without it, `count`=1 and `rd_doc`=0.
- Fill 3 entries, assert `rst` for one cycle together with a push -> `count`=0, `rd_valid`=0, `overflow`=0. The pointers wrap correctly on 6 further push/pop pairs.
- Ack with FIFO empty -> no state change and `count` remains 0.
